// File: rtl/filt4_tx.sv
// filt4_tx: valid/ready line driver holding each new level HOLD enabled cycles.
// Optional test-glitch injection is enabled with `define FILT4_TX_GLITCH_EN.
module filt4_tx #(
  parameter int HOLD = 12,
  parameter bit INIT_LVL = 1'b0
`ifdef FILT4_TX_GLITCH_EN
  , parameter int GLITCH_LEN = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  input  logic d_vld,
  output logic d_rdy,
  output logic y,
  output logic busy
`ifdef FILT4_TX_GLITCH_EN
  , input logic glitch_req
`endif
);
  localparam int CW = $clog2(HOLD + 1);
`ifdef FILT4_TX_GLITCH_EN
  typedef enum logic [2:0] {I0, I1, H0, H1, G} st_t;
`else
  typedef enum logic [2:0] {I0, I1, H0, H1} st_t;
`endif
  st_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic y_n, idle;
  assign idle = (st == I0) || (st == I1);
  assign d_rdy = en && idle;
  assign busy = !idle;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    y_n = y;
    if (en) begin
      case (st)
        I0, I1: begin
          if (d_vld) begin
            if (d != (st == I1)) begin
              st_n = d ? H1 : H0;
              y_n = d;
            end
          end
`ifdef FILT4_TX_GLITCH_EN
          else if (glitch_req) begin
            st_n = G;
            y_n = !y;
          end
`endif
        end
        H0, H1: begin
          cnt_n = (cnt == CW'(HOLD - 1)) ? '0 : cnt + CW'(1);
          st_n = (cnt == CW'(HOLD - 1)) ? ((st == H1) ? I1 : I0) : st;
        end
`ifdef FILT4_TX_GLITCH_EN
        // y is inverted here, so the idle level to return to is !y
        G: begin
          cnt_n = (cnt == CW'(GLITCH_LEN - 1)) ? '0 : cnt + CW'(1);
          st_n = (cnt == CW'(GLITCH_LEN - 1)) ? (y ? I0 : I1) : G;
          y_n = (cnt == CW'(GLITCH_LEN - 1)) ? !y : y;
        end
`endif
        default: begin
          st_n = INIT_LVL ? I1 : I0;
          cnt_n = '0;
          y_n = INIT_LVL;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= INIT_LVL ? I1 : I0;
      cnt <= '0;
      y <= INIT_LVL;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      y <= y_n;
    end
  end
endmodule

// File: tb/tb_filt4_tx.sv
// tb_filt4_tx: randomized scoreboard bench for filt4_tx with a time-based line model.
module tb_filt4_tx;
  localparam int HOLD = 12;
  localparam int GL = 3;
`ifdef FILT4_TX_GLITCH_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, d = 1'b0, d_vld = 1'b0, glitch_req = 1'b0;
  logic d_rdy, y, busy;
  always #5 clk = ~clk;
  filt4_tx dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .d_vld(d_vld),
    .d_rdy(d_rdy), .y(y), .busy(busy)
`ifdef FILT4_TX_GLITCH_EN
    , .glitch_req(glitch_req)
`endif
  );
  typedef struct {int c; logic l;} ev_t;
  ev_t q[$];
  int cyc = 0, pass_n = 0, tot = 0;
  logic mlvl = 1'b0;
  int rem = 0;
  bit gm = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic a, input logic b);
    tot++;
    if (a === b) pass_n++;
    else $display("FAIL %s: got %b want %b at cycle %0d", nm, a, b, cyc);
  endtask
  // monitor: every y edge must match the next expected edge in level and cycle
  initial begin
    logic ylast;
    ev_t e;
    ylast = y;
    forever begin
      @(negedge clk);
      if (!rst_n) ylast = y;
      else if (y !== ylast) begin
        ylast = y;
        if (q.size() == 0) begin
          tot++;
          $display("FAIL unexpected y edge: got %b want no edge at cycle %0d", y, cyc);
        end else begin
          e = q.pop_front();
          chk("y edge level", y, e.l);
          tot++;
          if (e.c == cyc) pass_n++;
          else $display("FAIL y edge time: got cycle %0d want cycle %0d", cyc, e.c);
        end
      end
    end
  end
  // driver + reference model: rem = enabled cycles left before the line is free again
  task automatic step(input bit e, input bit dd, input bit v, input bit g);
    @(negedge clk);
    en = e; d = dd; d_vld = v; glitch_req = g;
    #1;
    chk("d_rdy", d_rdy, e && rem == 0);
    chk("busy", busy, rem > 0);
    if (e) begin
      if (rem > 0) begin
        rem--;
        if (rem == 0 && gm) begin
          gm = 1'b0;
          q.push_back('{cyc + 1, mlvl});
        end
      end else if (v) begin
        if (dd != mlvl) begin
          mlvl = dd;
          rem = HOLD;
          q.push_back('{cyc + 1, dd});
        end
      end else if (g && GEN) begin
        rem = GL;
        gm = 1'b1;
        q.push_back('{cyc + 1, !mlvl});
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset y", y, 1'b0);
    chk("reset busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    repeat (HOLD) step(1, 1'($urandom), 1'($urandom), 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 40; k++) step(1, 1'(k), 1, 0);
    repeat (HOLD) step(1, mlvl, 0, 0);
    step(1, mlvl, 1, 0);
    step(1, 0, 0, 0);
    step(1, !mlvl, 1, 0);
    repeat (5) step(1, 0, 0, 0);
    repeat (7) step(0, 1'($urandom), 1, 0);
    repeat (HOLD) step(1, mlvl, 0, 0);
    if (mlvl == 1'b0) step(1, 1, 1, 0);
    repeat (4) step(1, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset y", y, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset d_rdy", d_rdy, en);
    mlvl = 1'b0; rem = 0; gm = 1'b0;
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1, 0, 0, 0);
    if (GEN) begin
      step(1, 0, 0, 1);
      repeat (GL + 2) step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      repeat (HOLD + 1) step(1, 0, 0, 0);
    end
    repeat (800) step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
                      GEN && $urandom_range(0, 5) == 0);
    repeat (HOLD + GL + 2) step(1, mlvl, 0, 0);
    tot++;
    if (q.size() == 0) pass_n++;
    else $display("FAIL missing y edges: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
